alu_div_seq: RTL and testbench
==============================

// Module: alu_div_seq
// PURPOSE
// Multi-cycle divide/remainder sequencer (RV32M DIV/DIVU/REM/REMU) with no private subtractor.
// It borrows the core's shared 32-bit ALU while busy, using its ADD/SUB/SLTU ops.
// Sits beside the ALU in the execute stage; core stalls on busy_o and muxes ALU inputs on alu_req_o.
// PARAMETERS
// XLEN      32  operand/result width; must match ALU width
// PORTS
// clk            in   1     rising-edge clock
// reset          in   1     synchronous, active-high reset
// start_i        in   1     request; sampled only in IDLE
// op_i           in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU; latched at accept
// dividend_i     in   XLEN  rs1 value; latched at accept
// divisor_i      in   XLEN  rs2 value; latched at accept
// busy_o         out  1     high from accept edge until the DONE cycle ends
// done_o         out  1     one-cycle pulse; result_o valid in that cycle
// result_o       out  XLEN  quotient or remainder; holds until next done_o
// alu_req_o      out  1     high in every non-IDLE/non-DONE state; core routes ALU to this block
// alu_src_a_o    out  XLEN  ALU operand A
// alu_src_b_o    out  XLEN  ALU operand B
// alu_control_o  out  4     ALU op: 0000 ADD, 0001 SUB, 0110 SLTU
// alu_result_i   in   XLEN  ALU result; combinational, consumed in the same cycle
// BEHAVIOUR
// Reset: state IDLE; busy_o=0, done_o=0, alu_req_o=0, result_o=0, alu_src_*=0, alu_control_o=0000.
// Reset mid-operation: abort immediately, no done_o, all internal state cleared.
// IDLE: when start_i=1, latch op/operands; set sgn = ~op_i[0]. Go to NEG_A.
// NEG_A: if sgn and A[31], drive SUB(0,A), else ADD(A,0); store result as |A|.
//   Record negq = sgn & (A[31]^B[31]) and negr = sgn & A[31].
// NEG_B: same operation for B, giving |B|; record dz = (B==0). Clear R, set Q=|A|, i=0. Go to CMP.
// CMP: form S = {R[XLEN-2:0], Q[XLEN-1]} and latch hi = R[XLEN-1].
//   Drive SLTU(S,|B|); latch ge = hi | ~alu_result_i[0]. Shift Q left by 1. Go to SUB.
// SUB: if ge, drive SUB(S,|B|), R <= alu_result_i, Q[0] <= 1.
//   Else drive ADD(S,0), R <= S, Q[0] <= 0.
//   i++; go to FIX_Q when i==XLEN-1 completes, else go to CMP.
// FIX_Q: if negq & ~dz, drive SUB(0,Q) and store to Q, else ADD(Q,0).
// FIX_R: if negr, drive SUB(0,R) and store to R, else ADD(R,0). Go to DONE.
// DONE: done_o=1, busy_o=1, alu_req_o=0. result_o <= op_i[1] ? R : Q. Next state IDLE.
// Fixed latency:
//   - every op visits all states, so done_o goes high exactly 2*XLEN+4 edges after the accept edge (68 for XLEN=32);
//   - earliest next accept is the edge leaving DONE;
//   - start_i while busy is ignored, not queued.
// Divide by zero (no special path beyond dz):
//   - quotient is all ones and remainder is the dividend, for both signed and unsigned ops;
//   - skipping FIX_Q under dz keeps the signed quotient at -1.
// Signed overflow (-2^31 / -1) falls out of the algorithm: quotient 0x80000000, remainder 0.
// |-2^31| is 0x80000000 and is treated as unsigned.
// All arithmetic is modulo 2^XLEN. hi covers the 33rd bit of S, so no wider datapath is needed.
// Idle outputs: when alu_req_o=0, alu_src_*=0 and alu_control_o=0000.
// TESTING
// DIVU 100/7 -> done_o exactly 68 cycles after accept, result 14; REMU same operands -> 2.
// DIV -7/2 -> quotient 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
// DIV 5/0 -> 0xFFFFFFFF; REMU 0x80000001/0 -> 0x80000001; DIV -5/0 -> 0xFFFFFFFF.
// DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0; DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
// start_i held high while busy with changed operands -> ignored; first result unaffected.
// Back-to-back accept on the edge after DONE is taken.
// reset pulsed at cycle 30 of a DIV -> busy_o=0 next cycle, no done_o; new DIVU 9/3 -> 3.

Source files
------------

// File: rtl/alu_div_seq_if.sv
// Core-side request/result bus and shared-ALU borrow bus for the sequential divider.
interface alu_div_seq_if #(parameter int XLEN = 32);
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic            alu_req_o;
  logic [XLEN-1:0] alu_src_a_o;
  logic [XLEN-1:0] alu_src_b_o;
  logic [3:0]      alu_control_o;
  logic [XLEN-1:0] alu_result_i;

  modport master (
    output start_i, op_i, dividend_i, divisor_i, alu_result_i,
    input  busy_o, done_o, result_o, alu_req_o, alu_src_a_o, alu_src_b_o, alu_control_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, alu_result_i,
    output busy_o, done_o, result_o, alu_req_o, alu_src_a_o, alu_src_b_o, alu_control_o
  );
endinterface

// File: rtl/alu_div_seq.sv
// RV32M DIV/DIVU/REM/REMU restoring divider that borrows the core's shared ALU
// for every add, subtract and compare; fixed latency of 2*XLEN+4 edges.
module alu_div_seq #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         reset,
  alu_div_seq_if.slave bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLTU = 4'b0110;

  typedef enum logic [2:0] {
    IDLE, NEG_A, NEG_B, CMP, SUB, FIX_Q, FIX_R, DONE
  } state_t;

  state_t          state, next_state;
  logic [1:0]      op_q;
  logic            sgn, negq, negr, dz, ge;
  logic [XLEN-1:0] a_q, b_q, r_q, q_q, s_q, result_q;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] s_cmb;
  logic            accept;
  logic [XLEN-1:0] alu_a, alu_b;
  logic [3:0]      alu_ctl;

  assign s_cmb = {r_q[XLEN-2:0], q_q[XLEN-1]};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // DONE doubles as an accept point so back-to-back operations lose no cycle.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_ctl    = ALU_ADD;
    case (state)
      IDLE: begin
        if (bus.start_i) begin
          accept     = 1'b1;
          next_state = NEG_A;
        end
      end
      NEG_A: begin
        if (sgn && a_q[XLEN-1]) begin
          alu_ctl = ALU_SUB;
          alu_b   = a_q;
        end else begin
          alu_a = a_q;
        end
        next_state = NEG_B;
      end
      NEG_B: begin
        if (sgn && b_q[XLEN-1]) begin
          alu_ctl = ALU_SUB;
          alu_b   = b_q;
        end else begin
          alu_a = b_q;
        end
        next_state = CMP;
      end
      CMP: begin
        alu_ctl    = ALU_SLTU;
        alu_a      = s_cmb;
        alu_b      = b_q;
        next_state = SUB;
      end
      SUB: begin
        alu_a = s_q;
        if (ge) begin
          alu_ctl = ALU_SUB;
          alu_b   = b_q;
        end
        next_state = (cnt == CW'(XLEN-1)) ? FIX_Q : CMP;
      end
      FIX_Q: begin
        if (negq && !dz) begin
          alu_ctl = ALU_SUB;
          alu_b   = q_q;
        end else begin
          alu_a = q_q;
        end
        next_state = FIX_R;
      end
      FIX_R: begin
        if (negr) begin
          alu_ctl = ALU_SUB;
          alu_b   = r_q;
        end else begin
          alu_a = r_q;
        end
        next_state = DONE;
      end
      DONE: begin
        if (bus.start_i) begin
          accept     = 1'b1;
          next_state = NEG_A;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The 33rd bit of the shifted remainder (old R MSB) forces a subtract,
  // which keeps the whole datapath XLEN bits wide.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= '0;
      sgn      <= 1'b0;
      negq     <= 1'b0;
      negr     <= 1'b0;
      dz       <= 1'b0;
      ge       <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      q_q      <= '0;
      s_q      <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q <= bus.op_i;
        sgn  <= ~bus.op_i[0];
        a_q  <= bus.dividend_i;
        b_q  <= bus.divisor_i;
      end
      case (state)
        NEG_A: begin
          a_q  <= bus.alu_result_i;
          negq <= sgn & (a_q[XLEN-1] ^ b_q[XLEN-1]);
          negr <= sgn & a_q[XLEN-1];
        end
        NEG_B: begin
          b_q <= bus.alu_result_i;
          dz  <= (b_q == '0);
          r_q <= '0;
          q_q <= a_q;
          cnt <= '0;
        end
        CMP: begin
          s_q <= s_cmb;
          ge  <= r_q[XLEN-1] | ~bus.alu_result_i[0];
          q_q <= {q_q[XLEN-2:0], 1'b0};
        end
        SUB: begin
          r_q    <= bus.alu_result_i;
          q_q[0] <= ge;
          cnt    <= cnt + 1'b1;
        end
        FIX_Q: q_q <= bus.alu_result_i;
        FIX_R: begin
          r_q      <= bus.alu_result_i;
          result_q <= op_q[1] ? bus.alu_result_i : q_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o        = (state != IDLE);
  assign bus.done_o        = (state == DONE);
  assign bus.alu_req_o     = (state != IDLE) && (state != DONE);
  assign bus.result_o      = result_q;
  assign bus.alu_src_a_o   = alu_a;
  assign bus.alu_src_b_o   = alu_b;
  assign bus.alu_control_o = alu_ctl;

endmodule

// File: tb/tb_alu_div_seq.sv
// Self-checking bench for alu_div_seq: models the shared ALU, runs directed
// vectors, multi-cycle corner sequences and random ops against a reference model.
module tb_alu_div_seq;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_div_seq_if #(.XLEN(32)) bus ();

  alu_div_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Shared core ALU, combinational.
  always_comb begin
    bus.alu_result_i = '0;
    case (bus.alu_control_o)
      4'b0000: bus.alu_result_i = bus.alu_src_a_o + bus.alu_src_b_o;
      4'b0001: bus.alu_result_i = bus.alu_src_a_o - bus.alu_src_b_o;
      4'b0110: bus.alu_result_i = {31'b0, bus.alu_src_a_o < bus.alu_src_b_o};
      default: bus.alu_result_i = '0;
    endcase
  end

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] refModel(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = '0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start_i    = 1'b1;
    bus.op_i       = op;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  task automatic waitDone(input int dropAt, output int lat, output logic [31:0] res);
    lat = 0;
    res = '0;
    while (lat < 120) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == dropAt) bus.start_i = 1'b0;
      if (bus.done_o) break;
    end
    res = bus.result_o;
  endtask

  task automatic checkIdle(input string name);
    @(posedge clk);
    #1;
    checkOutput({name, "_idle_busy"}, {31'b0, bus.busy_o}, 32'd0);
    checkOutput({name, "_idle_alu"},
                bus.alu_src_a_o | bus.alu_src_b_o | {28'b0, bus.alu_control_o} | {31'b0, bus.alu_req_o},
                32'd0);
  endtask

  task automatic runOp(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int lat;
    logic [31:0] res;
    applyStimulus(op, a, b);
    waitDone(-1, lat, res);
    checkOutput({name, "_lat"}, lat, 32'd68);
    checkOutput({name, "_res"}, res, exp);
    checkOutput({name, "_req_in_done"}, {31'b0, bus.alu_req_o}, 32'd0);
    checkIdle(name);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [31:0] res;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    vecs.push_back('{"divu_100_7",   2'b01, 32'd100,        32'd7,          32'd14});
    vecs.push_back('{"remu_100_7",   2'b11, 32'd100,        32'd7,          32'd2});
    vecs.push_back('{"div_m7_2",     2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD});
    vecs.push_back('{"rem_m7_2",     2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF});
    vecs.push_back('{"rem_7_m2",     2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1});
    vecs.push_back('{"div_5_0",      2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF});
    vecs.push_back('{"remu_x_0",     2'b11, 32'h8000_0001,  32'd0,          32'h8000_0001});
    vecs.push_back('{"div_m5_0",     2'b00, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF});
    vecs.push_back('{"rem_m5_0",     2'b10, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB});
    vecs.push_back('{"div_ovf",      2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000});
    vecs.push_back('{"rem_ovf",      2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0});
    vecs.push_back('{"divu_max_1",   2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF});
    vecs.push_back('{"divu_min_3",   2'b01, 32'h8000_0000,  32'd3,          32'h2AAA_AAAA});

    reset          = 1'b1;
    bus.start_i    = 1'b0;
    bus.op_i       = '0;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy",   {31'b0, bus.busy_o},    32'd0);
    checkOutput("rst_done",   {31'b0, bus.done_o},    32'd0);
    checkOutput("rst_req",    {31'b0, bus.alu_req_o}, 32'd0);
    checkOutput("rst_result", bus.result_o,           32'd0);
    checkOutput("rst_alu",    bus.alu_src_a_o | bus.alu_src_b_o | {28'b0, bus.alu_control_o}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      runOp(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    // start_i held while busy with different operands must be ignored
    applyStimulus(2'b01, 32'd100, 32'd7);
    bus.start_i    = 1'b1;
    bus.op_i       = 2'b10;
    bus.dividend_i = 32'd1000;
    bus.divisor_i  = 32'd3;
    waitDone(10, lat, res);
    checkOutput("ignore_lat", lat, 32'd68);
    checkOutput("ignore_res", res, 32'd14);
    checkIdle("ignore");

    // accept on the edge leaving DONE
    applyStimulus(2'b01, 32'd100, 32'd7);
    waitDone(-1, lat, res);
    checkOutput("b2b_first", res, 32'd14);
    bus.start_i    = 1'b1;
    bus.op_i       = 2'b11;
    bus.dividend_i = 32'd50;
    bus.divisor_i  = 32'd9;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    checkOutput("b2b_busy", {31'b0, bus.busy_o}, 32'd1);
    checkOutput("b2b_hold", bus.result_o, 32'd14);
    waitDone(-1, lat, res);
    checkOutput("b2b_lat", lat, 32'd68);
    checkOutput("b2b_second", res, 32'd5);
    checkIdle("b2b");

    // reset in the middle of a DIV aborts it silently
    applyStimulus(2'b00, 32'hFFFF_FFF9, 32'd2);
    repeat (29) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_busy",   {31'b0, bus.busy_o}, 32'd0);
    checkOutput("midrst_done",   {31'b0, bus.done_o}, 32'd0);
    checkOutput("midrst_result", bus.result_o,        32'd0);
    @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (bus.done_o || bus.busy_o) pulses++;
    end
    checkOutput("midrst_quiet", pulses, 32'd0);
    runOp("after_rst_divu", 2'b01, 32'd9, 32'd3, 32'd3);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       ra = 32'd0;
        1:       ra = 32'h8000_0000;
        2:       ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0:       rb = 32'd0;
        1:       rb = 32'd1;
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = 32'($urandom_range(1, 300));
        4:       rb = -32'($urandom_range(1, 300));
        default: rb = $urandom;
      endcase
      runOp($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, refModel(rop, ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
